camera_frame_capture: RTL and testbench

Single-clock front end for the parallel camera port: oversamples the camera pixel clock, byte-assembles RGB565 pixels from `cam_data`, and, when armed by the shutter switch, emits exactly one frame as a pixel stream. A small FIFO absorbs downstream stalls. The block sits directly upstream of the frame-buffer writer inside `soc_system` and drives that writer's valid/ready pixel input.

---
 rtl/camera_frame_capture_pkg.sv | 26 ++
 rtl/camera_frame_capture_if.sv | 24 ++
 rtl/camera_frame_capture_pix_fifo.sv | 55 +++++
 rtl/camera_frame_capture.sv | 177 +++++++++++++++++
 tb/tb_camera_frame_capture.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/camera_frame_capture_pkg.sv
// Shared types and widths for the camera capture front end.
package camera_pkg;

  localparam int X_W   = 10;
  localparam int Y_W   = 9;
  localparam int PIX_W = 16;

  // Capture sequencer states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  // One output FIFO entry: start-of-frame flag, coordinates, RGB565 pixel.
  typedef struct packed {
    logic             sof;
    logic [Y_W-1:0]   y;
    logic [X_W-1:0]   x;
    logic [PIX_W-1:0] data;
  } pix_entry_t;

  localparam int ENTRY_W = $bits(pix_entry_t);

endpackage

// File: rtl/camera_frame_capture_if.sv
// Valid/ready pixel stream from the capture block to the frame-buffer writer.
interface camera_frame_capture_if;
  import camera_pkg::*;

  logic [PIX_W-1:0] pix_data;
  logic [X_W-1:0]   pix_x;
  logic [Y_W-1:0]   pix_y;
  logic             pix_sof;
  logic             pix_valid;
  logic             pix_ready;

  // Producer side (capture block).
  modport master (
    output pix_data, pix_x, pix_y, pix_sof, pix_valid,
    input  pix_ready
  );

  // Consumer side (frame-buffer writer).
  modport slave (
    input  pix_data, pix_x, pix_y, pix_sof, pix_valid,
    output pix_ready
  );

endinterface

// File: rtl/camera_frame_capture_pix_fifo.sv
// Small synchronous first-word-fall-through FIFO built as a shift register.
// The head entry always sits in register slot 0, so the read data comes
// straight from a flop and never changes while the head is not consumed.
module pix_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]    cnt_q;

  logic          rd;
  logic          wr;
  logic [CW-1:0] wr_pos;
  logic [AW-1:0] wr_idx;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign rd      = rd_en && !empty;
  // A read in the same cycle frees the tail slot, so a full FIFO still
  // accepts the write.
  assign wr      = wr_en && (!full || rd);
  // When reading, everything shifts down by one, so the new entry lands one
  // slot lower than the current occupancy.
  assign wr_pos  = rd ? (cnt_q - CW'(1)) : cnt_q;
  assign wr_idx  = wr_pos[AW-1:0];
  assign rd_data = mem_q[0];

  // Shift on read, insert at the tail on write, track occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (rd) begin
        for (int i = 0; i < DEPTH - 1; i++) mem_q[i] <= mem_q[i+1];
      end
      if (wr) mem_q[wr_idx] <= wr_data;
      cnt_q <= cnt_q + CW'(wr) - CW'(rd);
    end
  end

endmodule

// File: rtl/camera_frame_capture.sv
// Parallel camera port front end: oversamples pclk, assembles RGB565 pixels
// from byte pairs and, once armed by the shutter, streams exactly one frame
// into a small FIFO feeding the frame-buffer writer.
module camera_frame_capture
  import camera_pkg::*;
#(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cam_pclk,
  input  logic                  cam_vsync,
  input  logic                  cam_href,
  input  logic [7:0]            cam_data,
  input  logic                  switch_shutter,
  camera_frame_capture_if.master pix,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  overflow
);

  // Bundle of everything that crosses in from the camera side:
  // [11] pclk, [10] vsync, [9] href, [8] shutter, [7:0] data.
  localparam int SW = 12;

  logic [SW-1:0] meta_q;
  logic [SW-1:0] sync_q;
  logic [3:0]    prev_q;

  logic       pclk_rise;
  logic       vs_fall;
  logic       vs_rise;
  logic       href_s;
  logic       href_fall;
  logic       sh_rise;
  logic [7:0] byte_s;

  state_t         state_q;
  logic [X_W-1:0] x_q;
  logic [Y_W-1:0] y_q;
  logic           phase_q;
  logic [7:0]     hi_q;
  logic           wr_q;
  pix_entry_t     wr_ent_q;
  logic           busy_q;
  logic           done_q;
  logic           ovf_q;

  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_rd;
  logic [ENTRY_W-1:0] fifo_dout;
  pix_entry_t       head;
  logic             drop;

  // Two-flop synchronizer for all camera inputs and the shutter, plus a third
  // stage on the control lines for edge detection. Data rides the same
  // two-flop path so it lines up with the pclk edge that samples it.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= {cam_pclk, cam_vsync, cam_href, switch_shutter, cam_data};
      sync_q <= meta_q;
      prev_q <= sync_q[11:8];
    end
  end

  assign pclk_rise = sync_q[11] & ~prev_q[3];
  assign vs_fall   = ~sync_q[10] &  prev_q[2];
  assign vs_rise   =  sync_q[10] & ~prev_q[2];
  assign href_s    =  sync_q[9];
  assign href_fall = ~sync_q[9]  &  prev_q[1];
  assign sh_rise   =  sync_q[8]  & ~prev_q[0];
  assign byte_s    =  sync_q[7:0];

  // Capture sequencer with byte assembly, coordinate counters and the
  // registered FIFO write request; busy/frame_done are registered here too.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      phase_q  <= 1'b0;
      hi_q     <= '0;
      wr_q     <= 1'b0;
      wr_ent_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      wr_q   <= 1'b0;
      done_q <= 1'b0;
      busy_q <= (state_q == ARM) || (state_q == CAPTURE);
      case (state_q)
        IDLE: begin
          if (sh_rise) state_q <= ARM;
        end
        ARM: begin
          if (vs_fall) begin
            state_q <= CAPTURE;
            x_q     <= '0;
            y_q     <= '0;
            phase_q <= 1'b0;
          end
        end
        CAPTURE: begin
          if (vs_rise) begin
            // End of frame: no byte from this cycle is written.
            state_q <= DONE;
            done_q  <= 1'b1;
          end else if (href_fall) begin
            // End of line: drop any half pixel and move to the next row.
            x_q     <= '0;
            phase_q <= 1'b0;
            if (y_q < Y_W'(V_ACTIVE)) y_q <= y_q + Y_W'(1);
          end else if (pclk_rise && href_s) begin
            phase_q <= ~phase_q;
            if (!phase_q) begin
              hi_q <= byte_s;
            end else begin
              wr_q          <= (x_q < X_W'(H_ACTIVE)) && (y_q < Y_W'(V_ACTIVE));
              wr_ent_q.sof  <= (x_q == '0) && (y_q == '0);
              wr_ent_q.y    <= y_q;
              wr_ent_q.x    <= x_q;
              wr_ent_q.data <= {hi_q, byte_s};
              if (x_q < X_W'(H_ACTIVE)) x_q <= x_q + X_W'(1);
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fifo_rd = pix.pix_ready && !fifo_empty;
  // A write into a full FIFO is lost unless the same cycle pops the head.
  assign drop    = wr_q && fifo_full && !fifo_rd;

  // Sticky overflow flag; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset)     ovf_q <= 1'b0;
    else if (drop) ovf_q <= 1'b1;
  end

  pix_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_q),
    .wr_data (wr_ent_q),
    .rd_en   (pix.pix_ready),
    .rd_data (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign head          = pix_entry_t'(fifo_dout);
  assign pix.pix_valid = !fifo_empty;
  assign pix.pix_data  = head.data;
  assign pix.pix_x     = head.x;
  assign pix.pix_y     = head.y;
  assign pix.pix_sof   = head.sof;

  assign busy       = busy_q;
  assign frame_done = done_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_camera_frame_capture.sv
// Bench for camera_frame_capture: small frame geometry, camera pclk at clk/4,
// expected pixel stream computed from frame descriptions.
module tb_camera_frame_capture;
  import camera_pkg::*;

  localparam int H  = 4;
  localparam int V  = 2;
  localparam int FD = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cam_pclk = 1'b0;
  logic       cam_vsync = 1'b1;
  logic       cam_href = 1'b0;
  logic [7:0] cam_data = 8'h00;
  logic       switch_shutter = 1'b0;
  logic       busy, frame_done, overflow;

  camera_frame_capture_if pix();

  camera_frame_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .reset(reset), .cam_pclk(cam_pclk), .cam_vsync(cam_vsync),
    .cam_href(cam_href), .cam_data(cam_data), .switch_shutter(switch_shutter),
    .pix(pix), .busy(busy), .frame_done(frame_done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit arm;
    int nl;
    int nb;
    int exp_pix;
    int exp_done;
  } vec_t;

  vec_t        vt [6];
  int          n_chk = 0;
  int          n_fail = 0;
  logic [35:0] expq [$];
  int          rx_cnt = 0;
  int          fd_cnt = 0;
  bit          busy_seen = 1'b0;
  int          rdy_mode = 0;
  int          push_limit = -1;
  int          zeros = 0;
  logic [35:0] cur;
  logic [35:0] prev_head = '0;
  bit          prev_stall = 1'b0;
  int          r0, f0, narm;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [35:0] e);
    if (push_limit != 0) begin
      expq.push_back(e);
      if (push_limit > 0) push_limit--;
    end
  endtask

  // Camera byte: data/href change while pclk is low, pclk rises 2 clk later.
  task automatic send_byte(input logic [7:0] b);
    cam_pclk = 1'b0; cam_data = b; cam_href = 1'b1; tick(2);
    cam_pclk = 1'b1; tick(2);
  endtask

  // Expected pixels of a line: byte pairs {b[2k], b[2k+1]}, at most H per
  // line, only for rows below V, sof on (0,0).
  task automatic drive_line(input int l, input int nb, input bit rnd, input bit cap);
    logic [7:0] b [16];
    for (int i = 0; i < nb; i++) b[i] = rnd ? 8'($urandom) : 8'(i);
    if (cap && l < V)
      for (int k = 0; k < nb / 2 && k < H; k++)
        push({(k == 0 && l == 0), 9'(l), 10'(k), b[2*k], b[2*k+1]});
    for (int i = 0; i < nb; i++) send_byte(b[i]);
    cam_pclk = 1'b0; cam_href = 1'b0; tick(8);
  endtask

  task automatic drive_frame(input bit arm, input int nl, input int nb, input bit rnd, input bit toggle_mid);
    cam_vsync = 1'b1; tick(4);
    if (arm) begin switch_shutter = 1'b1; tick(8); switch_shutter = 1'b0; end
    tick(2);
    cam_vsync = 1'b0; tick(8);
    for (int l = 0; l < nl; l++) begin
      drive_line(l, nb, rnd, arm);
      if (toggle_mid && l == 0) begin
        switch_shutter = 1'b1; tick(8); switch_shutter = 1'b0; tick(4);
      end
    end
    cam_vsync = 1'b1; tick(10);
  endtask

  task automatic drain();
    int t = 0;
    while (expq.size() != 0 && t < 400) begin tick(1); t++; end
    tick(6);
    chk("drain_empty", expq.size(), 0);
    chk("fifo_empty", pix.pix_valid, 0);
  endtask

  // Consumer side: ready pattern per mode.
  initial begin
    pix.pix_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: pix.pix_ready = 1'b1;
        1: begin
          if (zeros >= 3) pix.pix_ready = 1'b1;
          else pix.pix_ready = 1'($urandom_range(0, 1));
          zeros = pix.pix_ready ? 0 : zeros + 1;
        end
        default: pix.pix_ready = 1'b0;
      endcase
    end
  end

  // Monitor: sampled mid-cycle, sees the values the next rising edge acts on.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        cur = {pix.pix_sof, pix.pix_y, pix.pix_x, pix.pix_data};
        if (prev_stall) begin
          chk("hold_valid", pix.pix_valid, 1);
          chk("hold_head", cur, prev_head);
        end
        if (frame_done) fd_cnt++;
        if (busy) busy_seen = 1'b1;
        if (pix.pix_valid && pix.pix_ready) begin
          rx_cnt++;
          if (expq.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_pixel: got 0x%0h expected none", cur);
          end else begin
            chk("pixel", cur, expq.pop_front());
          end
        end
        prev_stall = pix.pix_valid && !pix.pix_ready;
        prev_head  = cur;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got no end of test expected end of test");
    $fatal(1, "timeout");
  end

  initial begin
    vt[0] = '{arm: 1'b0, nl: 2, nb: 8,  exp_pix: 0, exp_done: 0};
    vt[1] = '{arm: 1'b1, nl: 2, nb: 8,  exp_pix: 8, exp_done: 1};
    vt[2] = '{arm: 1'b1, nl: 2, nb: 11, exp_pix: 8, exp_done: 1};
    vt[3] = '{arm: 1'b1, nl: 3, nb: 8,  exp_pix: 8, exp_done: 1};
    vt[4] = '{arm: 1'b1, nl: 2, nb: 3,  exp_pix: 2, exp_done: 1};
    vt[5] = '{arm: 1'b1, nl: 1, nb: 0,  exp_pix: 0, exp_done: 1};

    reset = 1'b1; tick(3);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_valid", pix.pix_valid, 0);
    chk("rst_head", {pix.pix_sof, pix.pix_y, pix.pix_x, pix.pix_data}, 0);
    reset = 1'b0; tick(2);

    // Table-driven frames.
    for (int i = 0; i < 6; i++) begin
      r0 = rx_cnt; f0 = fd_cnt; busy_seen = 1'b0;
      drive_frame(vt[i].arm, vt[i].nl, vt[i].nb, 1'b0, 1'b0);
      drain();
      chk($sformatf("vec%0d_pix", i), rx_cnt - r0, vt[i].exp_pix);
      chk($sformatf("vec%0d_done", i), fd_cnt - f0, vt[i].exp_done);
      chk($sformatf("vec%0d_busy_seen", i), busy_seen, vt[i].arm);
      chk($sformatf("vec%0d_busy_idle", i), busy, 0);
    end

    // Shutter toggled during capture, then a frame with no shutter.
    r0 = rx_cnt; f0 = fd_cnt;
    drive_frame(1'b1, 3, 8, 1'b0, 1'b1);
    drive_frame(1'b0, 2, 8, 1'b0, 1'b0);
    drain();
    chk("toggle_pix", rx_cnt - r0, 8);
    chk("toggle_done", fd_cnt - f0, 1);

    // Random frames, random data and random (bounded-stall) ready.
    rdy_mode = 1; f0 = fd_cnt; narm = 0;
    for (int f = 0; f < 10; f++) begin
      bit a;
      a = ($urandom_range(0, 3) != 0);
      if (a) narm++;
      drive_frame(a, $urandom_range(1, 3), $urandom_range(1, 12), 1'b1, 1'b0);
    end
    drain();
    rdy_mode = 0;
    chk("rand_done", fd_cnt - f0, narm);
    chk("rand_ovf", overflow, 0);

    // Stalled consumer: only the first two pixels fit, rest dropped.
    rdy_mode = 2; push_limit = 2;
    drive_frame(1'b1, 1, 8, 1'b0, 1'b0);
    tick(4);
    chk("stall_ovf", overflow, 1);
    chk("stall_valid", pix.pix_valid, 1);
    chk("stall_head", {pix.pix_sof, pix.pix_y, pix.pix_x, pix.pix_data},
        {1'b1, 9'd0, 10'd0, 16'h0001});
    rdy_mode = 0; push_limit = -1;
    drain();
    chk("stall_ovf_sticky", overflow, 1);

    // Reset in the middle of a line.
    f0 = fd_cnt;
    cam_vsync = 1'b1; tick(4);
    switch_shutter = 1'b1; tick(8); switch_shutter = 1'b0; tick(2);
    cam_vsync = 1'b0; tick(8);
    for (int k = 0; k < 4; k++) push({(k == 0), 9'd0, 10'(k), 8'(2*k), 8'(2*k+1)});
    for (int i = 0; i < 5; i++) send_byte(8'(i));
    reset = 1'b1; tick(1);
    chk("mid_rst_valid", pix.pix_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", frame_done, 0);
    chk("mid_rst_ovf", overflow, 0);
    chk("mid_rst_head", {pix.pix_sof, pix.pix_y, pix.pix_x, pix.pix_data}, 0);
    reset = 1'b0;
    expq.delete();
    cam_pclk = 1'b0; cam_href = 1'b0; cam_vsync = 1'b1; tick(20);
    chk("mid_rst_no_done", fd_cnt - f0, 0);
    r0 = rx_cnt; f0 = fd_cnt;
    drive_frame(1'b1, 2, 8, 1'b0, 1'b0);
    drain();
    chk("rearm_pix", rx_cnt - r0, 8);
    chk("rearm_done", fd_cnt - f0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
